// File: rtl/tdc_pulse_gen.sv
// rtl/tdc_pulse_gen.sv - two-edge stimulus generator with programmable coarse interval and fine tap
// Optional feature macro: TDC_ARM_OUT_EN (adds tdc_arm output and a 2-cycle ARM_WAIT state)
module tdc_pulse_gen #(
    parameter int PULSE_W  = 2,
    parameter int COARSE_W = 29
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [39:0] interval,
    output logic        sig_out,
    output logic [4:0]  fine_sel,
    output logic        busy,
    output logic        done,
`ifdef TDC_ARM_OUT_EN
    output logic        clamp_err,
    output logic        tdc_arm
`else
    output logic        clamp_err
`endif
);

    localparam logic [COARSE_W-1:0] N_MIN = COARSE_W'(PULSE_W + 1);
    localparam logic [COARSE_W-1:0] C_ONE = COARSE_W'(1);
    localparam logic [3:0]          PW    = 4'(PULSE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE1,
        S_GAP,
`ifdef TDC_ARM_OUT_EN
        S_PULSE2,
        S_ARM_WAIT
`else
        S_PULSE2
`endif
    } state_t;

    state_t                state, state_n;
    logic [COARSE_W-1:0]   cnt, cnt_n;
    logic [COARSE_W-1:0]   neff, neff_n;
    logic [3:0]            pw_cnt, pw_cnt_n;
    logic                  sig_n, busy_n, done_n, clamp_n;
    logic [4:0]            fine_n;
    logic [COARSE_W-1:0]   n_req;
    logic                  n_small;
    logic                  unused_hi;
`ifdef TDC_ARM_OUT_EN
    logic                  arm_n;
`endif

    assign n_req     = interval[COARSE_W+4:5];
    assign n_small   = (n_req < N_MIN);
    assign unused_hi = ^interval[39:COARSE_W+5];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        neff_n   = neff;
        pw_cnt_n = pw_cnt;
        sig_n    = sig_out;
        busy_n   = busy;
        done_n   = 1'b0;
        fine_n   = fine_sel;
        clamp_n  = clamp_err;
`ifdef TDC_ARM_OUT_EN
        arm_n    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    neff_n   = n_small ? N_MIN : n_req;
                    clamp_n  = n_small;
                    fine_n   = interval[4:0];
                    busy_n   = 1'b1;
                    pw_cnt_n = 4'd1;
                    cnt_n    = C_ONE;
`ifdef TDC_ARM_OUT_EN
                    state_n  = S_ARM_WAIT;
                    arm_n    = 1'b1;
`else
                    state_n  = S_PULSE1;
                    sig_n    = 1'b1;
`endif
                end
            end
`ifdef TDC_ARM_OUT_EN
            S_ARM_WAIT: begin
                if (pw_cnt == 4'd2) begin
                    state_n  = S_PULSE1;
                    sig_n    = 1'b1;
                    pw_cnt_n = 4'd1;
                    cnt_n    = C_ONE;
                end else begin
                    pw_cnt_n = pw_cnt + 4'd1;
                end
            end
`endif
            S_PULSE1: begin
                // cnt tracks cycles since the first rise; it reaches at most PULSE_W+1 here
                cnt_n = cnt + C_ONE;
                if (pw_cnt == PW) begin
                    state_n = S_GAP;
                    sig_n   = 1'b0;
                end else begin
                    pw_cnt_n = pw_cnt + 4'd1;
                end
            end
            S_GAP: begin
                if (cnt == neff) begin
                    state_n  = S_PULSE2;
                    sig_n    = 1'b1;
                    pw_cnt_n = 4'd1;
                end else begin
                    cnt_n = cnt + C_ONE;
                end
            end
            S_PULSE2: begin
                if (pw_cnt == PW) begin
                    state_n = S_IDLE;
                    sig_n   = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    pw_cnt_n = pw_cnt + 4'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                sig_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase

        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            sig_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
`ifdef TDC_ARM_OUT_EN
            arm_n   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            neff      <= '0;
            pw_cnt    <= '0;
            sig_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fine_sel  <= '0;
            clamp_err <= 1'b0;
`ifdef TDC_ARM_OUT_EN
            tdc_arm   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            neff      <= neff_n;
            pw_cnt    <= pw_cnt_n;
            sig_out   <= sig_n;
            busy      <= busy_n;
            done      <= done_n;
            fine_sel  <= fine_n;
            clamp_err <= clamp_n;
`ifdef TDC_ARM_OUT_EN
            tdc_arm   <= arm_n;
`endif
        end
    end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// tb/tb_tdc_pulse_gen.sv - directed self-checking bench for tdc_pulse_gen (default build)
module tb_tdc_pulse_gen;

    localparam int PW = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [39:0] interval;
    logic        sig_out;
    logic [4:0]  fine_sel;
    logic        busy;
    logic        done;
    logic        clamp_err;

    int checks = 0;
    int errors = 0;

    tdc_pulse_gen #(.PULSE_W(PW), .COARSE_W(29)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .interval  (interval),
        .sig_out   (sig_out),
        .fine_sel  (fine_sel),
        .busy      (busy),
        .done      (done),
        .clamp_err (clamp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int n, input int f);
        interval = {6'h2A, 29'(n), 5'(f)};
        start    = 1'b1;
    endtask

    // Walks cycles T+1 .. T+neff+PW+1 after an accepted start, checking every output.
    task automatic follow(input int neff, input int f, input int clamp,
                          input int poke_k, input int chain_n, input int chain_f);
        int  last;
        logic exp_sig;
        last = neff + PW + 1;
        for (int k = 1; k <= last; k++) begin
            step();
            start    = (k == poke_k);
            interval = 40'hAB_CDEF_0123;
            exp_sig  = (k <= PW) || (k >= neff + 1 && k <= neff + PW);
            chk($sformatf("sig_k%0d_n%0d", k, neff), {31'd0, sig_out}, {31'd0, exp_sig});
            chk($sformatf("busy_k%0d_n%0d", k, neff), {31'd0, busy}, {31'd0, (k <= neff + PW)});
            chk($sformatf("done_k%0d_n%0d", k, neff), {31'd0, done}, {31'd0, (k == last)});
            if (k == 1) begin
                chk("fine_sel", {27'd0, fine_sel}, 32'(f));
                chk("clamp_err", {31'd0, clamp_err}, 32'(clamp));
            end
        end
        if (chain_n >= 0) begin
            launch(chain_n, chain_f);
        end else begin
            step();
            start = 1'b0;
            chk("post_sig", {31'd0, sig_out}, 32'd0);
            chk("post_done", {31'd0, done}, 32'd0);
            chk("post_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        interval = '0;
        step();
        step();
        chk("rst_sig", {31'd0, sig_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fine", {27'd0, fine_sel}, 32'd0);
        chk("rst_clamp", {31'd0, clamp_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // N=10 fine=7 with a stray start at T+5 that must be ignored
        launch(10, 7);
        follow(10, 7, 0, 5, -1, 0);

        // Clamp cases, then a start held in the done cycle chaining into a legal N=20
        launch(1, 3);
        follow(3, 3, 1, 0, -1, 0);
        launch(0, 1);
        follow(3, 1, 1, 0, 20, 9);
        follow(20, 9, 0, 0, -1, 0);

        // Smallest legal N: no clamp
        launch(3, 2);
        follow(3, 2, 0, 0, -1, 0);

        // Abort at T+6 of an N=10 run
        launch(10, 7);
        for (int k = 1; k <= 6; k++) begin
            step();
            start = 1'b0;
        end
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        step();
        chk("abort_sig", {31'd0, sig_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        abort = 1'b0;
        for (int k = 8; k <= 16; k++) begin
            step();
            chk($sformatf("abort_quiet_sig_k%0d", k), {31'd0, sig_out}, 32'd0);
            chk($sformatf("abort_quiet_done_k%0d", k), {31'd0, done}, 32'd0);
        end
        chk("abort_fine_hold", {27'd0, fine_sel}, 32'd7);

        // abort and start together in IDLE: start dropped
        launch(10, 5);
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abst_busy", {31'd0, busy}, 32'd0);
        chk("abst_sig", {31'd0, sig_out}, 32'd0);
        chk("abst_fine", {27'd0, fine_sel}, 32'd7);
        step();
        chk("abst_sig2", {31'd0, sig_out}, 32'd0);

        // Asynchronous reset mid-GAP of a clamped run
        launch(1, 4);
        for (int k = 1; k <= 3; k++) begin
            step();
            start = 1'b0;
        end
        chk("gap_busy", {31'd0, busy}, 32'd1);
        chk("gap_clamp", {31'd0, clamp_err}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sig", {31'd0, sig_out}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_fine", {27'd0, fine_sel}, 32'd0);
        chk("arst_clamp", {31'd0, clamp_err}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("final_sig", {31'd0, sig_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdc_pulse_gen.md
Name: tdc_pulse_gen

Overview:
Programmable two-edge stimulus generator, the transmit counterpart of the TDC measurement path. On a start request it drives two rising edges on sig_out, separated by a programmed coarse interval in clk cycles. It also presents a fine-delay tap select for an external delay element. It is used for self-test and calibration loopback into tdc_core; the interval word uses the same 40-bit measurement format.

Parameters:
PULSE_W, 2, high time of each output pulse in clk cycles (legal 1..15)
COARSE_W, 29, width of the coarse interval field

Ports:
clk  in  1  100 MHz clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  request generation; sampled only in IDLE
abort  in  1  synchronous cancel of an in-progress sequence
interval  in  40  [33:5] coarse N (cycles), [4:0] fine tap, [39:34] ignored
sig_out  out  1  generated stimulus, registered
fine_sel  out  5  fine tap latched at start, held until next accepted start
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the sequence completes normally
clamp_err  out  1  sticky; set when the requested N was clamped

Behaviour:
- Reset (async): sig_out=0, fine_sel=0, busy=0, done=0, clamp_err=0, state IDLE, counters 0. Assertion mid-sequence forces sig_out low immediately.
- States: IDLE, PULSE1, GAP, PULSE2.
- Start acceptance: start=1 in IDLE at cycle T.
  - Latch Neff = max(N, PULSE_W+1) and fine_sel=interval[4:0].
  - If N < PULSE_W+1 (including N=0), clamp to PULSE_W+1 and set clamp_err. clamp_err clears only on the next accepted start with a legal N, or on reset.
- Timing, referenced to the clock edge ending cycle T:
  - PULSE1: sig_out=1 in cycles T+1 .. T+PULSE_W; busy=1 from T+1.
  - GAP: sig_out=0 until the second rise.
  - PULSE2: sig_out=1 in cycles T+1+Neff .. T+Neff+PULSE_W. Rise-to-rise interval is exactly Neff cycles.
  - Cycle T+1+Neff+PULSE_W: sig_out=0, busy=0, done=1 for one cycle, state IDLE. A new start is accepted in that same cycle.
- start while busy: ignored; no queuing.
- Coarse counter: COARSE_W bits, counts from 1 at the first rise. Max N = 2^29-1 requires no wrap handling; the counter never exceeds Neff.
- abort:
  - abort=1 in any non-IDLE state: next cycle sig_out=0, busy=0, state IDLE, no done pulse; fine_sel holds.
  - abort in IDLE: no effect.
  - abort and start in the same IDLE cycle: abort wins and start is dropped.
- interval may change freely after the acceptance cycle; only the value at T is used.

Optional Feature:
TDC_ARM_OUT_EN
- Defined:
  - Adds output tdc_arm (1 bit, reset 0), pulsed high for exactly cycle T+1 after acceptance.
  - Inserts an ARM_WAIT state of 2 cycles, so the first rise moves to T+3. All later timing shifts by +2; the rise-to-rise interval is unchanged.
  - abort during ARM_WAIT behaves as in any other non-IDLE state.
- Undefined: no tdc_arm port, no ARM_WAIT state; timing exactly as in Behaviour.

Test Plan:
- PULSE_W=2, start at T with N=10, fine=7:
  - sig_out rises at T+1 and T+11, falls at T+3 and T+13.
  - done at T+13, busy high T+1..T+12, fine_sel=7, clamp_err=0.
- N=1, PULSE_W=2 -> Neff=3, rises at T+1 and T+4, clamp_err=1. Then N=20 -> clamp_err=0, rises 20 cycles apart.
- start re-asserted at T+5 during an N=10 run -> ignored; a single edge pair and a single done. start in the done cycle -> next sequence rises in the following cycle.
- abort at T+6 of an N=10 run -> sig_out=0 and busy=0 at T+7, no second rise, no done. Repeat with rst_n low mid-GAP -> all outputs 0 asynchronously.
- Loopback into tdc_core (arm pulsed before start), N=1000, fine=12 -> tdc_core measurement[33:5]=1000, meas_valid pulses once.
- TDC_ARM_OUT_EN defined, N=10 -> tdc_arm high only at T+1, sig_out rises at T+3 and T+13, done at T+15.
